// File: rtl/cordic_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_scheduler
//
// Shares one iterative CORDIC core between two requesters. A round-robin
// arbiter grants one angle at a time. The scheduler then pulses the core's
// active-low reset for one cycle and releases the core. It waits for the core
// to report completion and presents the captured cos/sin on a valid/ready
// response port.
//
// FSM: IDLE (grant) -> LOAD (core held in reset) -> RUN (core released)
//      -> DONE (response held until taken) -> IDLE
//
// Optional feature (macro CORDIC_SCHED_TIMEOUT_EN):
//   defined   : RUN is abandoned after TIMEOUT cycles without a qualifying
//               CORE_HALT. The result completes with RSP_ERR=1 and zero data.
//   undefined : RUN waits indefinitely and RSP_ERR is constant 0.
//
// Parameters:
//   TIMEOUT  RUN cycles allowed before error completion (timeout build only)
//   SETTLE   leading RUN cycles during which CORE_HALT is ignored
//
// Ports:
//   CLK                     clock, rising edge
//   RESET                   synchronous, active-low reset
//   REQ0_VALID/REQ1_VALID   requester has an angle
//   REQ0_ANGLE/REQ1_ANGLE   8-bit unsigned angle (256 = 90 degrees)
//   REQ0_READY/REQ1_READY   combinational grant, only in IDLE
//   RSP_VALID/RSP_READY     response handshake
//   RSP_ID                  requester index owning the response
//   RSP_COS/RSP_SIN         captured core results
//   RSP_ERR                 response terminated by timeout
//   CORE_ANGLE              angle presented to the core
//   CORE_RESET              active-low core reset; 1 only while running
//   CORE_HALT               core iteration complete
//   CORE_COS/CORE_SIN       core results
// -----------------------------------------------------------------------------
module cordic_scheduler #(
    parameter int TIMEOUT = 32,
    parameter int SETTLE  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    input  logic [7:0] REQ0_ANGLE,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic [7:0] REQ1_ANGLE,
    output logic       REQ1_READY,
    output logic       RSP_VALID,
    input  logic       RSP_READY,
    output logic       RSP_ID,
    output logic [7:0] RSP_COS,
    output logic [7:0] RSP_SIN,
    output logic       RSP_ERR,
    output logic [7:0] CORE_ANGLE,
    output logic       CORE_RESET,
    input  logic       CORE_HALT,
    input  logic [7:0] CORE_COS,
    input  logic [7:0] CORE_SIN
);

    localparam int MAX_COUNT = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_reg;
    logic            last_reg;       // index served most recently
    logic            rsp_valid_reg;
    logic            rsp_id_reg;
    logic [7:0]      rsp_cos_reg;
    logic [7:0]      rsp_sin_reg;
    logic [7:0]      core_angle_reg;
    logic            core_reset_reg;
    logic [CW-1:0]   counter_reg;

    logic            grant_valid;
    logic            grant_id;
    logic [7:0]      grant_angle;
    logic            take;
    logic [1:0]      ready_vec;
    logic            halt_ok;

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (REQ0_VALID && REQ1_VALID) begin
            grant_valid = 1'b1;
            grant_id    = ~last_reg;
        end else if (REQ0_VALID) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (REQ1_VALID) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    assign grant_angle = grant_id ? REQ1_ANGLE : REQ0_ANGLE;

    // RESET gates the grant so no handshake can complete while in reset.
    assign take = RESET && (state_reg == IDLE) && grant_valid;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign ready_vec[gi] = take && (grant_id == 1'(gi));
    end

    assign REQ0_READY = ready_vec[0];
    assign REQ1_READY = ready_vec[1];

    // A HALT still high from the previous run must not complete the new run.
    assign halt_ok = CORE_HALT && (counter_reg >= CW'(SETTLE));

`ifdef CORDIC_SCHED_TIMEOUT_EN
    logic rsp_err_reg;
    // RUN cycles are numbered from 0, so index TIMEOUT-1 is the last allowed.
    logic timed_out;
    assign timed_out = (counter_reg >= CW'(TIMEOUT - 1));
    assign RSP_ERR   = rsp_err_reg;
`else
    assign RSP_ERR   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg      <= IDLE;
            last_reg       <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_cos_reg    <= 8'h00;
            rsp_sin_reg    <= 8'h00;
            core_angle_reg <= 8'h00;
            core_reset_reg <= 1'b0;
            counter_reg    <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            rsp_err_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take) begin
                        core_angle_reg <= grant_angle;
                        rsp_id_reg     <= grant_id;
                        last_reg       <= grant_id;
                        state_reg      <= LOAD;
                    end
                end
                LOAD: begin
                    counter_reg    <= '0;
                    core_reset_reg <= 1'b1;
                    state_reg      <= RUN;
                end
                RUN: begin
                    if (halt_ok) begin
                        rsp_cos_reg    <= CORE_COS;
                        rsp_sin_reg    <= CORE_SIN;
                        rsp_valid_reg  <= 1'b1;
                        core_reset_reg <= 1'b0;
                        state_reg      <= DONE;
`ifdef CORDIC_SCHED_TIMEOUT_EN
                        rsp_err_reg    <= 1'b0;
                    end else if (timed_out) begin
                        rsp_cos_reg    <= 8'h00;
                        rsp_sin_reg    <= 8'h00;
                        rsp_err_reg    <= 1'b1;
                        rsp_valid_reg  <= 1'b1;
                        core_reset_reg <= 1'b0;
                        state_reg      <= DONE;
`endif
                    end else if (counter_reg != '1) begin
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (RSP_READY) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign RSP_VALID  = rsp_valid_reg;
    assign RSP_ID     = rsp_id_reg;
    assign RSP_COS    = rsp_cos_reg;
    assign RSP_SIN    = rsp_sin_reg;
    assign CORE_ANGLE = core_angle_reg;
    assign CORE_RESET = core_reset_reg;

endmodule

// File: tb/tb_cordic_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cordic_scheduler
//
// Self-checking bench for cordic_scheduler. Each transaction is a fixed
// schedule: grant at the IDLE sample, LOAD, then RUN cycles 0..max(lat,SETTLE),
// then DONE. Here lat is the RUN cycle at which the bench's core model raises
// HALT. A table of hand-derived records covers arbitration, hold and stuck-HALT
// cases. Randomized transactions follow, checked against a round-robin pointer
// and latency model. Hand-written sequences cover reset in RUN and the timeout
// path.
// -----------------------------------------------------------------------------
module tb_cordic_scheduler;

    localparam int TIMEOUT = 32;
    localparam int SETTLE  = 2;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       REQ0_VALID, REQ1_VALID;
    logic [7:0] REQ0_ANGLE, REQ1_ANGLE;
    logic       REQ0_READY, REQ1_READY;
    logic       RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
    logic [7:0] RSP_COS, RSP_SIN;
    logic [7:0] CORE_ANGLE;
    logic       CORE_RESET, CORE_HALT;
    logic [7:0] CORE_COS, CORE_SIN;

    always #5 CLK = ~CLK;

    cordic_scheduler #(.TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ0_VALID (REQ0_VALID),
        .REQ0_ANGLE (REQ0_ANGLE),
        .REQ0_READY (REQ0_READY),
        .REQ1_VALID (REQ1_VALID),
        .REQ1_ANGLE (REQ1_ANGLE),
        .REQ1_READY (REQ1_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_READY  (RSP_READY),
        .RSP_ID     (RSP_ID),
        .RSP_COS    (RSP_COS),
        .RSP_SIN    (RSP_SIN),
        .RSP_ERR    (RSP_ERR),
        .CORE_ANGLE (CORE_ANGLE),
        .CORE_RESET (CORE_RESET),
        .CORE_HALT  (CORE_HALT),
        .CORE_COS   (CORE_COS),
        .CORE_SIN   (CORE_SIN)
    );

    int checks = 0;
    int errors = 0;
    bit ptr;   // model of the last-served index

    typedef struct {
        bit         v0;
        bit         v1;
        logic [7:0] a0;
        logic [7:0] a1;
        int         lat;
        logic [7:0] cv;
        logic [7:0] sv;
        int         hold;
        int         exp_id;
        bit         late1;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete transaction starting at an IDLE sample.
    task automatic txn(input bit v0, input bit v1,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input int lat, input logic [7:0] cv, input logic [7:0] sv,
                       input int hold, input int exp_id, input bit late1);
        int         kcap;
        logic [7:0] exp_angle;
        kcap      = (lat > SETTLE) ? lat : SETTLE;
        exp_angle = (exp_id == 1) ? a1 : a0;
        REQ0_VALID = v0;
        REQ1_VALID = v1;
        REQ0_ANGLE = a0;
        REQ1_ANGLE = a1;
        CORE_HALT  = (lat == 0);
        CORE_COS   = cv;
        CORE_SIN   = sv;
        RSP_READY  = 1'b0;
        #1;
        chk("idle_rsp_valid", RSP_VALID, 0);
        chk("grant_ready0", REQ0_READY, (exp_id == 0));
        chk("grant_ready1", REQ1_READY, (exp_id == 1));
        step();
        // LOAD
        chk("load_core_reset", CORE_RESET, 0);
        chk("load_core_angle", CORE_ANGLE, exp_angle);
        chk("load_ready", REQ0_READY | REQ1_READY, 0);
        step();
        for (int k = 0; k <= kcap; k++) begin
            chk("run_core_reset", CORE_RESET, 1);
            chk("run_rsp_valid", RSP_VALID, 0);
            if (lat == 0 || k >= lat)
                CORE_HALT = 1'b1;
            else if (k < SETTLE)
                CORE_HALT = 1'($urandom_range(0, 1));
            else
                CORE_HALT = 1'b0;
            #1;
            chk("run_ready", REQ0_READY | REQ1_READY, 0);
            step();
        end
        for (int h = 0; h <= hold; h++) begin
            chk("done_rsp_valid", RSP_VALID, 1);
            chk("done_rsp_id", RSP_ID, exp_id);
            chk("done_rsp_cos", RSP_COS, cv);
            chk("done_rsp_sin", RSP_SIN, sv);
            chk("done_rsp_err", RSP_ERR, 0);
            chk("done_core_reset", CORE_RESET, 0);
            chk("done_core_angle", CORE_ANGLE, exp_angle);
            CORE_COS  = 8'($urandom);
            CORE_SIN  = 8'($urandom);
            CORE_HALT = 1'($urandom_range(0, 1));
            if (late1) begin
                REQ1_VALID = 1'b1;
                REQ1_ANGLE = 8'hC3;
            end
            RSP_READY = (h == hold);
            #1;
            chk("done_ready", REQ0_READY | REQ1_READY, 0);
            step();
        end
        RSP_READY = 1'b0;
        chk("bubble_rsp_valid", RSP_VALID, 0);
        chk("bubble_core_reset", CORE_RESET, 0);
        if (late1) begin
            #1;
            chk("late_ready1", REQ1_READY, 1);
        end
        $display("txn id=%0d angle=%02h lat=%0d cos=%02h sin=%02h hold=%0d",
                 exp_id, exp_angle, lat, cv, sv, hold);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 8'h10, 8'h80, 3, 8'h11, 8'h22, 0, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h10, 8'h80, 5, 8'h33, 8'h44, 1, 1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h80, 0, 8'h55, 8'h66, 0, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h10, 8'h80, 2, 8'h77, 8'h88, 2, 1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h40, 8'h00, 9, 8'h6D, 8'h2D, 3, 0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 8'hFF, 0, 8'h99, 8'hAA, 0, 1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'h01, 8'h02, 1, 8'hBB, 8'hCC, 1, 0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h20, 8'h00, 4, 8'hDD, 8'hEE, 2, 0, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 8'h20, 8'hC3, 1, 8'h01, 8'hFE, 0, 1, 1'b0};

        RESET      = 1'b0;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b0;
        REQ0_ANGLE = 8'h5A;
        REQ1_ANGLE = 8'h00;
        RSP_READY  = 1'b0;
        CORE_HALT  = 1'b0;
        CORE_COS   = 8'h00;
        CORE_SIN   = 8'h00;
        step();
        step();
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_id", RSP_ID, 0);
        chk("rst_rsp_cos", RSP_COS, 0);
        chk("rst_rsp_sin", RSP_SIN, 0);
        chk("rst_rsp_err", RSP_ERR, 0);
        chk("rst_core_angle", CORE_ANGLE, 0);
        chk("rst_core_reset", CORE_RESET, 0);
        chk("rst_ready0", REQ0_READY, 0);
        RESET = 1'b1;
        ptr   = 1'b1;

        // Hand-derived table: pointer starts at 1, so REQ0 wins the first tie.
        for (int i = 0; i < 9; i++)
            txn(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1, vecs[i].lat,
                vecs[i].cv, vecs[i].sv, vecs[i].hold, vecs[i].exp_id, vecs[i].late1);
        ptr = 1'b1;   // last table record served REQ1

        // Randomized transactions against the round-robin and latency model.
        for (int t = 0; t < 40; t++) begin
            int   gap;
            int   r;
            int   e;
            bit   v0;
            bit   v1;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                REQ0_VALID = 1'b0;
                REQ1_VALID = 1'b0;
                #1;
                chk("gap_ready", REQ0_READY | REQ1_READY, 0);
                step();
                chk("gap_rsp_valid", RSP_VALID, 0);
            end
            r  = $urandom_range(1, 3);
            v0 = (r == 1) || (r == 3);
            v1 = (r == 2) || (r == 3);
            if (v0 && v1) e = ptr ? 0 : 1;
            else          e = v0 ? 0 : 1;
            ptr = (e == 1);
            txn(v0, v1, 8'($urandom), 8'($urandom), $urandom_range(0, 10),
                8'($urandom), 8'($urandom), $urandom_range(0, 3), e, 1'b0);
        end

        // Reset during RUN cycle 4 abandons the transaction.
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b0;
        REQ0_ANGLE = 8'h33;
        CORE_HALT  = 1'b0;
        RSP_READY  = 1'b0;
        step();
        step();
        repeat (4) step();
        chk("run4_core_reset", CORE_RESET, 1);
        chk("run4_core_angle", CORE_ANGLE, 8'h33);
        RESET      = 1'b0;
        REQ0_VALID = 1'b0;
        step();
        chk("mid_rst_rsp_valid", RSP_VALID, 0);
        chk("mid_rst_rsp_id", RSP_ID, 0);
        chk("mid_rst_rsp_cos", RSP_COS, 0);
        chk("mid_rst_rsp_sin", RSP_SIN, 0);
        chk("mid_rst_rsp_err", RSP_ERR, 0);
        chk("mid_rst_core_angle", CORE_ANGLE, 0);
        chk("mid_rst_core_reset", CORE_RESET, 0);
        REQ1_VALID = 1'b1;
        #1;
        chk("mid_rst_ready1", REQ1_READY, 0);
        RESET = 1'b1;
        ptr   = 1'b1;
        txn(1'b0, 1'b1, 8'h00, 8'h5A, 3, 8'h12, 8'h34, 1, 1, 1'b0);

        // Core that never halts.
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b0;
        REQ0_ANGLE = 8'h77;
        CORE_HALT  = 1'b0;
        CORE_COS   = 8'hAA;
        CORE_SIN   = 8'h55;
        step();
        step();
`ifdef CORDIC_SCHED_TIMEOUT_EN
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("to_run_rsp_valid", RSP_VALID, 0);
            step();
        end
        chk("to_rsp_valid", RSP_VALID, 1);
        chk("to_rsp_err", RSP_ERR, 1);
        chk("to_rsp_cos", RSP_COS, 0);
        chk("to_rsp_sin", RSP_SIN, 0);
        chk("to_rsp_id", RSP_ID, 0);
        $display("timeout response err=%0d", RSP_ERR);
`else
        for (int k = 0; k < 200; k++) begin
            chk("no_to_rsp_valid", RSP_VALID, 0);
            chk("no_to_core_reset", CORE_RESET, 1);
            step();
        end
        chk("no_to_rsp_err", RSP_ERR, 0);
        $display("no timeout: still running after 200 cycles");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_scheduler.md
CORDIC_SCHEDULER -- requirements
Module: cordic_scheduler

Interface
REQ-001 Parameter: TIMEOUT, 32, maximum RUN-state cycles to wait for CORE_HALT before error completion.
REQ-002 Parameter: SETTLE, 2, initial RUN cycles during which CORE_HALT is ignored.
REQ-003 CLK  input  1  clock; all state changes on posedge.
REQ-004 RESET  input  1  synchronous, active-low reset.
REQ-005 REQ0_VALID / REQ1_VALID  input  1  requester n has an angle to convert.
REQ-006 REQ0_ANGLE / REQ1_ANGLE  input  8  requester n angle, unsigned, 256 = 90 degrees scale.
REQ-007 REQ0_READY / REQ1_READY  output  1  requester n accepted; transfer when VALID&READY.
REQ-008 RSP_VALID  output  1  result available.
REQ-009 RSP_READY  input  1  consumer takes result.
REQ-010 RSP_ID  output  1  index of the requester that owns the result.
REQ-011 RSP_COS / RSP_SIN  output  8  captured core results.
REQ-012 RSP_ERR  output  1  result terminated by timeout.
REQ-013 CORE_ANGLE  output  8  angle driven to the shared CORDIC core.
REQ-014 CORE_RESET  output  1  active-low reset pulse to the core; 1 = core runs.
REQ-015 CORE_HALT  input  1  core iteration complete.
REQ-016 CORE_COS / CORE_SIN  input  8  core outputs.

Function
REQ-017 FSM states: IDLE, LOAD, RUN, DONE.
REQ-018 IDLE: grant one requester; READY is combinational, high only for the granted requester, and only in IDLE.
REQ-019 Arbitration: round-robin with a 1-bit last-served pointer; both valid -> grant the one not last served; one valid -> grant it.
REQ-020 On handshake: latch the angle into CORE_ANGLE and the requester index into RSP_ID; IDLE->LOAD; the pointer updates to the served index.
REQ-021 LOAD lasts exactly 1 cycle with CORE_RESET=0, then RUN.
REQ-022 CORE_RESET=0 in IDLE, LOAD and DONE; =1 only in RUN.
REQ-023 CORE_ANGLE holds its latched value from LOAD through DONE.
REQ-024 RUN: cycle counter starts at 0; CORE_HALT is ignored while counter<SETTLE.
REQ-025 RUN with CORE_HALT=1 and counter>=SETTLE: capture CORE_COS/CORE_SIN into RSP_COS/RSP_SIN, set RSP_ERR=0, go to DONE; RSP_VALID=1 on the next cycle.
REQ-026 DONE: RSP_VALID, RSP_ID, RSP_COS, RSP_SIN and RSP_ERR are held stable until RSP_VALID&RSP_READY, then go to IDLE.
REQ-027 RSP_VALID is 0 in all states except DONE; there is one IDLE bubble between completion and the next grant.
REQ-028 Any REQ_VALID arriving in LOAD, RUN or DONE gets READY=0; requesters hold VALID and ANGLE until accepted.
REQ-029 The counter saturates; no wrap-around.
REQ-030 Angle is passed unmodified, with no range check.

Reset
REQ-031 RESET=0 at any posedge: state IDLE, pointer=1 so that REQ0 wins the first tie.
REQ-032 Also on reset: RSP_VALID=0, RSP_ID=0, RSP_COS=0, RSP_SIN=0, RSP_ERR=0, CORE_ANGLE=0, CORE_RESET=0, counter=0.
REQ-033 Reset mid-RUN or mid-DONE abandons the transaction with no response.
REQ-034 No handshake completes during any cycle in which RESET=0.

Configuration
REQ-035 Macro CORDIC_SCHED_TIMEOUT_EN defined: in RUN, counter reaching TIMEOUT without a qualifying CORE_HALT forces DONE with RSP_ERR=1 and RSP_COS=RSP_SIN=0.
REQ-036 Macro CORDIC_SCHED_TIMEOUT_EN undefined: RUN waits indefinitely for CORE_HALT, and RSP_ERR is tied to 0.

Verification
REQ-037 REQ0 angle 0x40, core model asserting HALT 9 RUN cycles after release with cos 0x6D / sin 0x2D -> RSP_VALID, RSP_ID=0, RSP_COS=0x6D, RSP_SIN=0x2D, RSP_ERR=0; the response is held for 3 cycles of RSP_READY=0.
REQ-038 REQ0 and REQ1 both valid continuously from reset, angles 0x10 and 0x80 -> grants follow REQ0, REQ1, REQ0, REQ1; RSP_ID alternates 0,1,0,1; CORE_ANGLE alternates 0x10 / 0x80.
REQ-039 CORE_HALT stuck at 1 from the previous run -> HALT is ignored for 2 RUN cycles; capture no earlier than RUN cycle 2.
REQ-040 With CORDIC_SCHED_TIMEOUT_EN defined, CORE_HALT stuck at 0 -> after 32 RUN cycles, RSP_VALID=1, RSP_ERR=1, RSP_COS=RSP_SIN=0; without the macro, RSP_VALID stays 0 for 200 cycles.
REQ-041 RESET=0 asserted in RUN cycle 4 -> the next cycle shows all outputs at reset values; the next REQ1-only request is granted, with RSP_ID=1.
REQ-042 REQ1_VALID rising during DONE -> REQ1_READY stays 0 until the cycle after RSP_READY handshake.
